// File: rtl/floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// floor_request_scheduler
//
// Upstream stage of the elevator controller. Latches call-button presses for
// every floor and runs a SCAN (up/down sweep) policy to pick the next target
// floor for the elevator core. A request is cleared when the core reports
// arrival at the commanded floor.
//
// Optional build macro: SERVED_COUNT_EN
//   When defined, adds served_count[7:0], a wrapping count of arrival clears.
//
// Ports:
//   clk           divided system clock, rising-edge logic
//   rst           synchronous, active-high reset
//   stop          freeze FSM, dwell counter, target and dir; requests still latch
//   btn           call buttons, one per floor, level, synchronous to clk
//   cur_floor     current floor reported by the elevator core
//   target        floor requested from the elevator core
//   target_valid  high while motion toward target is being commanded
//   pending       latched, unserved requests (bit i = floor i)
//   dir           sweep direction, 1 = up, 0 = down
//   served_count  (SERVED_COUNT_EN only) number of served requests, wraps
// -----------------------------------------------------------------------------
module floor_request_scheduler #(
    parameter int FLOOR_W      = 2,
    parameter int DWELL_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    stop,
    input  logic [2**FLOOR_W-1:0]   btn,
    input  logic [FLOOR_W-1:0]      cur_floor,
    output logic [FLOOR_W-1:0]      target,
    output logic                    target_valid,
    output logic [2**FLOOR_W-1:0]   pending,
    output logic                    dir
`ifdef SERVED_COUNT_EN
    ,
    output logic [7:0]              served_count
`endif
);

    localparam int NUM_FLOORS = 2**FLOOR_W;
    localparam logic [3:0] DWELL_RELOAD = 4'(DWELL_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE        = 2'd0,
        ST_MOVING_UP   = 2'd1,
        ST_MOVING_DOWN = 2'd2,
        ST_DWELL       = 2'd3
    } state_t;

    // Index of the lowest set bit; zero when the mask is empty.
    function automatic logic [FLOOR_W-1:0] lowest_set(input logic [NUM_FLOORS-1:0] m);
        logic [FLOOR_W-1:0] idx;
        idx = {FLOOR_W{1'b0}};
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (m[i]) begin
                idx = FLOOR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Index of the highest set bit; zero when the mask is empty.
    function automatic logic [FLOOR_W-1:0] highest_set(input logic [NUM_FLOORS-1:0] m);
        logic [FLOOR_W-1:0] idx;
        idx = {FLOOR_W{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (m[i]) begin
                idx = FLOOR_W'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [NUM_FLOORS-1:0]   btn_q, btn_d;
    logic [FLOOR_W-1:0]      target_q, target_d;
    logic                    target_valid_q, target_valid_d;
    logic                    dir_q, dir_d;
    logic [3:0]              dwell_cnt_q, dwell_cnt_d;
`ifdef SERVED_COUNT_EN
    logic [7:0]              served_count_q, served_count_d;
`endif

    logic [NUM_FLOORS-1:0]   above_s, below_s, cur_onehot_s;
    logic [NUM_FLOORS-1:0]   up_between_s, down_between_s;
    logic [NUM_FLOORS-1:0]   btn_edge_s, set_mask_s, clear_mask_s;
    logic                    moving_s, arrive_s, cur_press_s;
    state_t                  dec_state_s;
    logic [FLOOR_W-1:0]      dec_target_s;
    logic                    dec_dir_s;

    // Floor position masks relative to cur_floor and the active target.
    always_comb begin
        above_s        = {NUM_FLOORS{1'b0}};
        below_s        = {NUM_FLOORS{1'b0}};
        cur_onehot_s   = {NUM_FLOORS{1'b0}};
        up_between_s   = {NUM_FLOORS{1'b0}};
        down_between_s = {NUM_FLOORS{1'b0}};
        for (int i = 0; i < NUM_FLOORS; i++) begin
            above_s[i]        = (FLOOR_W'(i) > cur_floor);
            below_s[i]        = (FLOOR_W'(i) < cur_floor);
            cur_onehot_s[i]   = (FLOOR_W'(i) == cur_floor);
            up_between_s[i]   = (FLOOR_W'(i) > cur_floor) && (FLOOR_W'(i) < target_q);
            down_between_s[i] = (FLOOR_W'(i) < cur_floor) && (FLOOR_W'(i) > target_q);
        end
    end

    // SCAN decision: keep sweeping in dir while requests remain ahead,
    // otherwise reverse. A request left only at the current floor is served
    // by targeting the current floor, so it clears on the next cycle instead
    // of leaving the FSM stuck with a nonzero pending mask.
    always_comb begin
        dec_state_s  = ST_IDLE;
        dec_target_s = target_q;
        dec_dir_s    = dir_q;
        if (pending_q == {NUM_FLOORS{1'b0}}) begin
            dec_state_s = ST_IDLE;
        end else if (dir_q) begin
            if (|(pending_q & above_s)) begin
                dec_state_s  = ST_MOVING_UP;
                dec_target_s = lowest_set(pending_q & above_s);
            end else if (|(pending_q & below_s)) begin
                dec_state_s  = ST_MOVING_DOWN;
                dec_target_s = highest_set(pending_q & below_s);
                dec_dir_s    = 1'b0;
            end else begin
                dec_state_s  = ST_MOVING_UP;
                dec_target_s = cur_floor;
            end
        end else begin
            if (|(pending_q & below_s)) begin
                dec_state_s  = ST_MOVING_DOWN;
                dec_target_s = highest_set(pending_q & below_s);
            end else if (|(pending_q & above_s)) begin
                dec_state_s  = ST_MOVING_UP;
                dec_target_s = lowest_set(pending_q & above_s);
                dec_dir_s    = 1'b1;
            end else begin
                dec_state_s  = ST_MOVING_DOWN;
                dec_target_s = cur_floor;
            end
        end
    end

    // Request capture and arrival clearing. A press of the floor the car is
    // sitting at (idle, dwelling, or arriving this cycle) is not latched.
    always_comb begin
        btn_d       = btn;
        btn_edge_s  = btn & ~btn_q;
        moving_s    = (state_q == ST_MOVING_UP) || (state_q == ST_MOVING_DOWN);
        arrive_s    = moving_s && (cur_floor == target_q) && !stop;
        cur_press_s = |(btn_edge_s & cur_onehot_s);
        if (!moving_s || arrive_s) begin
            set_mask_s = btn_edge_s & ~cur_onehot_s;
        end else begin
            set_mask_s = btn_edge_s;
        end
        if (arrive_s) begin
            clear_mask_s = cur_onehot_s;
        end else begin
            clear_mask_s = {NUM_FLOORS{1'b0}};
        end
        pending_d = (pending_q | set_mask_s) & ~clear_mask_s;
    end

    // Next-state logic for the sweep FSM, target, direction and dwell timer.
    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        dir_d       = dir_q;
        dwell_cnt_d = dwell_cnt_q;
        if (stop) begin
            state_d = state_q;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    state_d  = dec_state_s;
                    target_d = dec_target_s;
                    dir_d    = dec_dir_s;
                end
                ST_MOVING_UP: begin
                    if (arrive_s) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = DWELL_RELOAD;
                    end else if (|(pending_q & up_between_s)) begin
                        target_d = lowest_set(pending_q & up_between_s);
                    end else begin
                        target_d = target_q;
                    end
                end
                ST_MOVING_DOWN: begin
                    if (arrive_s) begin
                        state_d     = ST_DWELL;
                        dwell_cnt_d = DWELL_RELOAD;
                    end else if (|(pending_q & down_between_s)) begin
                        target_d = highest_set(pending_q & down_between_s);
                    end else begin
                        target_d = target_q;
                    end
                end
                ST_DWELL: begin
                    // A fresh press at this floor keeps the doors open longer.
                    if (cur_press_s) begin
                        dwell_cnt_d = DWELL_RELOAD;
                    end else if (dwell_cnt_q == 4'd0) begin
                        state_d  = dec_state_s;
                        target_d = dec_target_s;
                        dir_d    = dec_dir_s;
                    end else begin
                        dwell_cnt_d = dwell_cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        target_valid_d = (state_d == ST_MOVING_UP) || (state_d == ST_MOVING_DOWN);
    end

`ifdef SERVED_COUNT_EN
    // Wrapping count of served requests.
    always_comb begin
        if (arrive_s) begin
            served_count_d = served_count_q + 8'd1;
        end else begin
            served_count_d = served_count_q;
        end
    end
`endif

    // State register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            pending_q      <= {NUM_FLOORS{1'b0}};
            btn_q          <= {NUM_FLOORS{1'b0}};
            target_q       <= {FLOOR_W{1'b0}};
            target_valid_q <= 1'b0;
            dir_q          <= 1'b1;
            dwell_cnt_q    <= 4'd0;
`ifdef SERVED_COUNT_EN
            served_count_q <= 8'd0;
`endif
        end else begin
            state_q        <= state_d;
            pending_q      <= pending_d;
            btn_q          <= btn_d;
            target_q       <= target_d;
            target_valid_q <= target_valid_d;
            dir_q          <= dir_d;
            dwell_cnt_q    <= dwell_cnt_d;
`ifdef SERVED_COUNT_EN
            served_count_q <= served_count_d;
`endif
        end
    end

    assign target       = target_q;
    assign target_valid = target_valid_q;
    assign pending      = pending_q;
    assign dir          = dir_q;
`ifdef SERVED_COUNT_EN
    assign served_count = served_count_q;
`endif

endmodule

// File: tb/tb_floor_request_scheduler.sv
// -----------------------------------------------------------------------------
// Directed, self-checking bench for floor_request_scheduler. Inputs change
// 1 ns after each rising edge; outputs are checked at the same point.
// -----------------------------------------------------------------------------
module tb_floor_request_scheduler;

    logic       clk;
    logic       rst;
    logic       stop;
    logic [3:0] btn;
    logic [1:0] cur_floor;
    logic [1:0] target;
    logic       target_valid;
    logic [3:0] pending;
    logic       dir;
`ifdef SERVED_COUNT_EN
    logic [7:0] served_count;
`endif

    int checks = 0;
    int errors = 0;

    floor_request_scheduler #(
        .FLOOR_W      (2),
        .DWELL_CYCLES (4)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stop         (stop),
        .btn          (btn),
        .cur_floor    (cur_floor),
        .target       (target),
        .target_valid (target_valid),
        .pending      (pending),
        .dir          (dir)
`ifdef SERVED_COUNT_EN
        ,
        .served_count (served_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [3:0] e_pend,
                             input logic [1:0] e_tgt, input logic e_tv, input logic e_dir);
        check({tag, ".pending"}, 8'(pending), 8'(e_pend));
        check({tag, ".target"}, 8'(target), 8'(e_tgt));
        check({tag, ".target_valid"}, 8'(target_valid), 8'(e_tv));
        check({tag, ".dir"}, 8'(dir), 8'(e_dir));
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stop = 1'b0; btn = 4'b0000; cur_floor = 2'd0;
        tick(); tick();
        rst = 1'b0;
        check_all("reset", 4'b0000, 2'd0, 1'b0, 1'b1);

        // Single request to floor 2 from floor 0.
        btn = 4'b0100; tick();
        check("t1_latch.pending", 8'(pending), 8'h04);
        check("t1_latch.tv", 8'(target_valid), 8'h00);
        btn = 4'b0000; tick();
        check_all("t1_go", 4'b0100, 2'd2, 1'b1, 1'b1);
        cur_floor = 2'd1; tick();
        check("t1_pass1.target", 8'(target), 8'h02);
        cur_floor = 2'd2; tick();
        check_all("t1_arrive", 4'b0000, 2'd2, 1'b0, 1'b1);

        // Only floor 0 pending while sweeping up at floor 2: reverse after dwell.
        btn = 4'b0001; tick();
        btn = 4'b0000;
        check("t2_latch.pending", 8'(pending), 8'h01);
        tick(); tick();
        check("t2_dwell_end.tv", 8'(target_valid), 8'h00);
        check("t2_dwell_end.dir", 8'(dir), 8'h01);
        tick();
        check_all("t2_reverse", 4'b0001, 2'd0, 1'b1, 1'b0);
        cur_floor = 2'd1; tick();
        cur_floor = 2'd0; tick();
        check_all("t2_arrive", 4'b0000, 2'd0, 1'b0, 1'b0);

        // Current-floor press during dwell reloads the timer, is not latched.
        tick(); tick();
        btn = 4'b0001; tick();
        check("t3_curpress.pending", 8'(pending), 8'h00);
        btn = 4'b1000; tick();
        btn = 4'b0000;
        check("t3_latch3.pending", 8'(pending), 8'h08);
        tick(); tick();
        check("t3_still_dwell.tv", 8'(target_valid), 8'h00);
        tick();
        check_all("t3_go_up", 4'b1000, 2'd3, 1'b1, 1'b1);

        // Retarget to floor 2 while moving up from floor 1 toward 3.
        cur_floor = 2'd1; tick();
        check("t4_pass1.target", 8'(target), 8'h03);
        btn = 4'b0100; tick();
        btn = 4'b0000;
        check("t4_latch2.pending", 8'(pending), 8'h0c);
        check("t4_latch2.target", 8'(target), 8'h03);
        tick();
        check_all("t4_retarget", 4'b1100, 2'd2, 1'b1, 1'b1);
        cur_floor = 2'd2; tick();
        check_all("t4_arrive2", 4'b1000, 2'd2, 1'b0, 1'b1);
        tick(); tick(); tick();
        check("t4_dwell.tv", 8'(target_valid), 8'h00);
        tick();
        check_all("t4_resume3", 4'b1000, 2'd3, 1'b1, 1'b1);

        // Freeze with stop: requests latch, arrival deferred.
        stop = 1'b1; cur_floor = 2'd3; btn = 4'b0001; tick();
        btn = 4'b0000;
        check_all("t5_stop1", 4'b1001, 2'd3, 1'b1, 1'b1);
        tick();
        check_all("t5_stop2", 4'b1001, 2'd3, 1'b1, 1'b1);
        stop = 1'b0; tick();
        check_all("t5_arrive3", 4'b0001, 2'd3, 1'b0, 1'b1);
        tick(); tick(); tick(); tick();
        check_all("t5_reverse", 4'b0001, 2'd0, 1'b1, 1'b0);

        // Reset in the middle of a move.
        cur_floor = 2'd2; btn = 4'b1000; tick();
        check("t6_latch3.pending", 8'(pending), 8'h09);
        rst = 1'b1; btn = 4'b0000; cur_floor = 2'd0; tick();
        rst = 1'b0;
        check_all("t6_reset", 4'b0000, 2'd0, 1'b0, 1'b1);

        // Current-floor press while idle is ignored.
        btn = 4'b0001; tick();
        btn = 4'b0000; tick();
        check("t7_idle_cur.pending", 8'(pending), 8'h00);
        check("t7_idle_cur.tv", 8'(target_valid), 8'h00);

        // Floors 1 and 3 latched together; nearest first; held button latches once.
        btn = 4'b1010; tick();
        check("t8_latch.pending", 8'(pending), 8'h0a);
        tick();
        check_all("t8_go1", 4'b1010, 2'd1, 1'b1, 1'b1);
        cur_floor = 2'd1; tick();
        check_all("t8_arrive1", 4'b1000, 2'd1, 1'b0, 1'b1);
        tick(); tick(); tick();
        check("t8_held.pending", 8'(pending), 8'h08);
        btn = 4'b0000; tick();
        check_all("t8_go3", 4'b1000, 2'd3, 1'b1, 1'b1);
`ifdef SERVED_COUNT_EN
        check("t8_served_count", served_count, 8'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
